icache_refill: RTL and testbench
================================

# icache_refill

Line-refill engine for the instruction cache. On a miss it issues one AXI INCR read burst for the line-aligned address, writes each returned word into the icache data RAM's write port, forwards the missed word to the fetch stage on arrival, and pulses completion after the last beat. It sits between the icache controller (miss side), the icache data RAM (write side) and the AXI read channels.

## Interface
- LINE_WORDS, 8, words per cache line (power of two, 2..16)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- miss_req  in  1  miss request, held until miss_ack
- miss_addr  in  32  byte address of missed instruction
- miss_ack  out  1  one-cycle pulse: request latched
- fwd_valid  out  1  one-cycle pulse: missed word available
- fwd_data  out  32  missed word, valid with fwd_valid
- refill_done  out  1  one-cycle pulse: line fully written
- refill_err  out  1  with refill_done: some beat had rresp != 0
- araddr  out  32  line-aligned address
- arlen  out  8  LINE_WORDS-1
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  data valid
- rready  out  1  ready for data
- ram_en  out  1  data RAM enable
- ram_wen  out  4  byte write enables (4'hF when writing)
- ram_addr  out  32  byte address of word being written
- ram_wdata  out  32  word being written

## Operation
- States: IDLE, AR, R, DONE.
- IDLE: rready=0, arvalid=0. If miss_req=1: latch line_addr = {miss_addr[31:OFF], OFF'b0} with OFF = log2(LINE_WORDS)+2, latch crit = miss_addr[OFF-1:2], clear beat counter and err flag, pulse miss_ack, go AR.
- AR: arvalid=1, araddr=line_addr stable. On arvalid&&arready go R.
- R: rready=1. Each beat (rvalid&&rready): ram_en=1, ram_wen=4'hF, ram_addr=line_addr+4*cnt, ram_wdata=rdata, combinational in the same cycle; err |= (rresp!=0); if cnt==crit, fwd_valid=1 and fwd_data=rdata in the following cycle (registered); cnt+=1 (width log2(LINE_WORDS), wraps only at end).
- Beat termination: burst ends on the beat with rlast=1 or on beat LINE_WORDS-1, whichever first; go DONE. If rlast arrives early, remaining words are not written and refill_err is set. Beats after cnt==LINE_WORDS-1 without rlast: refill_err is set and the engine keeps rready=1, discarding data, until rlast, then DONE.
- DONE: refill_done=1, refill_err=err for one cycle, go IDLE. miss_req sampled again only in IDLE (next cycle at earliest).
- miss_req while not IDLE: ignored, no ack.
- ram_en/ram_wen are 0 outside accepted beats.

## Timing
- Reset (rst=0, async): state=IDLE; all outputs 0 except arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01 (constants). Reset mid-burst abandons the transaction; no further RAM writes.
- miss_req at cycle 0 -> miss_ack cycle 0 (combinational from IDLE&&miss_req), arvalid from cycle 1.
- arready same cycle as arvalid -> rready from next cycle.
- RAM write: same cycle as handshake beat; zero buffering, one beat per cycle max.
- fwd_valid: one cycle after the critical beat.
- refill_done: cycle after the terminating beat.
- Minimum miss-to-done with zero-wait slave: LINE_WORDS+3 cycles.

## Test plan
- LINE_WORDS=8, miss_addr=0x1FC0_0014, arready immediate, 8 back-to-back beats D0..D7 -> araddr=0x1FC0_0000, arlen=7; RAM writes to 0x..00..0x..1C with D0..D7; fwd_data=D5 one cycle after beat 5; refill_done, refill_err=0.
- Same request with random rvalid gaps and arready delayed 3 cycles -> arvalid/araddr held stable; writes only on handshake cycles; identical RAM contents.
- rresp=2'b10 on beat 3 -> all 8 words still written, refill_done with refill_err=1.
- rlast asserted on beat 5 -> exactly 6 RAM writes, refill_done with refill_err=1, next miss accepted.
- miss_req held high through refill with a new address -> no second ack until IDLE; second refill uses second address.
- rst driven low during beat 4 -> all outputs zero immediately, no further ram_en; after release a new miss completes normally.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one AXI INCR burst per miss, each beat
// written straight into the data RAM, critical word forwarded to fetch.
module icache_refill #(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req,
    input  logic [31:0] miss_addr,
    output logic        miss_ack,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        refill_done,
    output logic        refill_err,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata
);

    localparam int CW  = $clog2(LINE_WORDS);
    localparam int OFF = CW + 2;

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t          state, state_nxt;
    logic [31:0]     line_addr;
    logic [CW-1:0]   crit;
    logic [CW-1:0]   cnt;
    logic            err;
    logic            drain;
    logic            beat;
    logic            wr;
    logic            last_word;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^miss_addr[1:0];

    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign araddr  = line_addr;

    // Once the last line word is written without rlast, the rest of the burst is drained unwritten.
    assign beat      = (state == R) && rvalid;
    assign wr        = beat && !drain;
    assign last_word = (cnt == CW'(LINE_WORDS - 1));

    assign ram_en    = wr;
    assign ram_wen   = wr ? 4'hF : 4'h0;
    assign ram_addr  = wr ? (line_addr + {{(30-CW){1'b0}}, cnt, 2'b00}) : 32'h0;
    assign ram_wdata = wr ? rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        miss_ack    = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_req) begin
                    miss_ack  = 1'b1;
                    state_nxt = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nxt = DONE;
            end
            DONE: begin
                refill_done = 1'b1;
                refill_err  = err;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_addr <= 32'h0;
            crit      <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            drain     <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_data  <= 32'h0;
        end else begin
            fwd_valid <= wr && (cnt == crit);
            if (wr && (cnt == crit)) fwd_data <= rdata;
            if (miss_ack) begin
                line_addr <= {miss_addr[31:OFF], {OFF{1'b0}}};
                crit      <= miss_addr[OFF-1:2];
                cnt       <= '0;
                err       <= 1'b0;
                drain     <= 1'b0;
            end else if (wr) begin
                cnt <= cnt + CW'(1);
                // Bad response, short burst, or over-long burst all flag the line as bad.
                if ((rresp != 2'b00) || (rlast != last_word)) err <= 1'b1;
                if (last_word && !rlast) drain <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: AXI slave driven cycle by cycle with
// hand-computed expected RAM writes, forwarded word and completion status.
module tb_icache_refill;

    localparam int LW = 8;

    logic        clk;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        miss_ack;
    logic        fwd_valid;
    logic [31:0] fwd_data;
    logic        refill_done;
    logic        refill_err;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    icache_refill #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .refill_done(refill_done), .refill_err(refill_err),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dat(input logic [31:0] seed, input int b);
        return seed ^ (32'(b) * 32'h1111_0001);
    endfunction

    // One complete miss: slave sends nbeats beats, rlast on the final one.
    task automatic refill(input logic [31:0] addr, input int ar_dly, input bit gaps,
                          input int bad, input int nbeats, input bit hold,
                          input logic [31:0] haddr, input int abort, input logic [31:0] seed);
        logic [31:0] line;
        int          crit;
        int          beat;
        bit          fwd_pend;
        bit          done_seen;
        bit          exp_err;
        line     = addr & 32'hFFFF_FFE0;
        crit     = int'(addr[4:2]);
        exp_err  = (nbeats != LW) || (bad >= 0 && bad < nbeats);
        beat     = 0;
        fwd_pend = 1'b0;
        done_seen = 1'b0;

        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = addr;
        #1;
        chk("ack", miss_ack, 1);
        chk("done_clr", refill_done, 0);
        chk("arvalid_idle", arvalid, 0);
        @(posedge clk);

        for (int d = 0; d <= ar_dly; d++) begin
            @(negedge clk);
            miss_req = hold;
            if (hold) miss_addr = haddr;
            arready = (d == ar_dly);
            #1;
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, line);
            chk("noack_ar", miss_ack, 0);
            chk("rready_ar", rready, 0);
            @(posedge clk);
        end

        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            @(negedge clk);
            arready = 1'b0;
            chk("fwd_v", fwd_valid, 32'(fwd_pend));
            if (fwd_pend) chk("fwd_d", fwd_data, dat(seed, crit));
            rvalid = !(gaps && (cyc % 3 == 1));
            rdata  = dat(seed, beat);
            rresp  = (beat == bad) ? 2'b10 : 2'b00;
            rlast  = (beat == nbeats - 1);
            #1;
            chk("rready", rready, 1);
            chk("noack_r", miss_ack, 0);
            if (rvalid && beat == abort) begin
                rst = 1'b0;
                #1;
                chk("rst_ram_en", ram_en, 0);
                chk("rst_ram_wen", ram_wen, 0);
                chk("rst_ram_addr", ram_addr, 0);
                chk("rst_rready", rready, 0);
                chk("rst_arvalid", arvalid, 0);
                chk("rst_araddr", araddr, 0);
                chk("rst_fwd_v", fwd_valid, 0);
                chk("rst_fwd_d", fwd_data, 0);
                chk("rst_done", refill_done, 0);
                chk("rst_arlen", arlen, 7);
                rvalid   = 1'b0;
                rlast    = 1'b0;
                rresp    = 2'b00;
                miss_req = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_hold_ram_en", ram_en, 0);
                rst = 1'b1;
                return;
            end
            chk("ram_en", ram_en, 32'(rvalid && beat < LW));
            if (rvalid && beat < LW) begin
                chk("ram_wen", ram_wen, 4'hF);
                chk("ram_addr", ram_addr, line + 32'(4 * beat));
                chk("ram_wdata", ram_wdata, dat(seed, beat));
            end
            fwd_pend = rvalid && (beat == crit) && (beat < LW);
            @(posedge clk);
            if (rvalid) begin
                if (rlast) done_seen = 1'b1;
                beat++;
            end
        end
        chk("burst_end", 32'(done_seen), 1);

        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("fwd_v", fwd_valid, 32'(fwd_pend));
        if (fwd_pend) chk("fwd_d", fwd_data, dat(seed, crit));
        #1;
        chk("done", refill_done, 1);
        chk("err", refill_err, 32'(exp_err));
        chk("rready_done", rready, 0);
        chk("ram_en_done", ram_en, 0);
        chk("noack_done", miss_ack, 0);
    endtask

    initial begin
        rst = 1'b0;
        miss_req = 1'b0; miss_addr = 32'h0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ack", miss_ack, 0);
        chk("reset_arvalid", arvalid, 0);
        chk("reset_rready", rready, 0);
        chk("reset_done", refill_done, 0);
        chk("reset_ram_en", ram_en, 0);
        chk("reset_arlen", arlen, 7);
        chk("reset_arsize", arsize, 3'b010);
        chk("reset_arburst", arburst, 2'b01);
        rst = 1'b1;

        refill(32'h1FC0_0014, 0, 1'b0, -1, 8,  1'b0, 32'h0, -1, 32'hA5A5_0000);
        refill(32'h1FC0_0014, 3, 1'b1, -1, 8,  1'b0, 32'h0, -1, 32'hA5A5_0000);
        refill(32'h1FC0_0014, 0, 1'b0,  3, 8,  1'b0, 32'h0, -1, 32'h3C3C_1000);
        refill(32'h1FC0_0014, 0, 1'b0, -1, 6,  1'b0, 32'h0, -1, 32'h5A00_0F00);
        refill(32'h1FC0_0014, 1, 1'b0, -1, 8,  1'b1, 32'h0000_1238, -1, 32'h0F0F_0000);
        refill(32'h0000_1238, 0, 1'b0, -1, 8,  1'b0, 32'h0, -1, 32'h7777_0000);
        refill(32'h8000_0040, 0, 1'b0, -1, 10, 1'b0, 32'h0, -1, 32'h1234_0000);
        refill(32'h1FC0_0014, 0, 1'b0, -1, 8,  1'b0, 32'h0,  4, 32'hDEAD_0000);
        refill(32'h4000_009C, 2, 1'b1, -1, 8,  1'b0, 32'h0, -1, 32'hBEEF_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
